config_loader: RTL and testbench

Serial configuration writer for the fabric's configuration shift chains, such as the LE-input interconnect chain with 3-bit selectors per LE input. It accepts configuration words over a valid/ready stream, serialises them MSB-first into a chain's serial input, and then releases configuration mode. An optional verify pass recirculates the chain once and compares a CRC of the read-back bits with the CRC of the loaded bits. It sits between the bitstream source (host/SPI bridge) and one or more daisy-chained config shift registers.

---
 rtl/cfg_pkg.sv | 23 ++
 rtl/config_crc8.sv | 25 ++
 rtl/config_loader.sv | 149 ++++++++++++++
 tb/tb_config_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the configuration loader.
//   cfg_state_e : loader FSM states
//   CRC_POLY    : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   crc8_step   : one serial CRC-8 update, MSB-first
package cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SHIFT  = 3'd2,
    S_VERIFY = 3'd3,
    S_FINISH = 3'd4
  } cfg_state_e;

  localparam logic [7:0] CRC_POLY = 8'h07;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/config_crc8.sv
// config_crc8: serial CRC-8 register (poly 0x07, init 0x00).
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0x00 (wins over en)
//   en       : absorb din this cycle
//   din      : serial data bit
//   crc      : current CRC value
module config_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);
  import cfg_pkg::*;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/config_loader.sv
// config_loader: serial writer for configuration shift chains.
// Accepts WORD_W-bit words on a valid/ready stream, shifts them MSB-first
// into the chain, optionally recirculates the chain once and compares a
// CRC-8 of the read-back bits against the CRC-8 of the loaded bits.
//   clk, rst          : clock, synchronous active-high reset
//   start, verify_en  : begin a load (verify_en sampled with start)
//   s_data/valid/ready: configuration word stream
//   cfg_en, cfg_shift : chain config enable / shift enable
//   cfg_sdo, cfg_sdi  : chain serial in / serial out
//   busy, done, error : status (error sticky until next accepted start)
module config_loader #(
  parameter int unsigned CHAIN_LEN = 48,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_en,
  output logic              cfg_shift,
  output logic              cfg_sdo,
  input  logic              cfg_sdi,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import cfg_pkg::*;

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WB_W  = $clog2(WORD_W + 1);

  cfg_state_e        r_state, w_next;
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WB_W-1:0]   r_wbit;
  logic              r_ver;
  logic              r_s_ready, r_cfg_en, r_cfg_shift, r_busy, r_done, r_error;
  logic              w_hs, w_chain_last, w_word_last, w_crc_clr;
  logic [7:0]        w_ld_crc, w_rb_crc;

  // s_ready is high exactly while in FETCH, so the handshake is state + valid.
  assign w_hs         = (r_state == S_FETCH) && s_valid;
  assign w_chain_last = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_word_last  = (r_wbit == WB_W'(WORD_W - 1));
  assign w_crc_clr    = (r_state == S_IDLE) && start;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (w_hs) w_next = S_SHIFT;
      S_SHIFT: begin
        // Chain-full takes priority: trailing bits of the last word are dropped.
        if (w_chain_last)     w_next = r_ver ? S_VERIFY : S_FINISH;
        else if (w_word_last) w_next = S_FETCH;
      end
      S_VERIFY: if (w_chain_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_bit_cnt   <= '0;
      r_wbit      <= '0;
      r_ver       <= 1'b0;
      r_s_ready   <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_cfg_shift <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Status outputs are flops decoded from the next state.
      r_s_ready   <= (w_next == S_FETCH);
      r_cfg_en    <= (w_next inside {S_FETCH, S_SHIFT, S_VERIFY});
      r_busy      <= (w_next inside {S_FETCH, S_SHIFT, S_VERIFY});
      r_cfg_shift <= (w_next inside {S_SHIFT, S_VERIFY});
      r_done      <= (w_next == S_FINISH);

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ver     <= verify_en;
            r_bit_cnt <= '0;
            r_wbit    <= '0;
            r_word    <= '0;
            r_error   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_hs) begin
            r_word <= s_data;
            r_wbit <= '0;
          end
        end
        S_SHIFT: begin
          r_word    <= r_word << 1;
          r_wbit    <= r_wbit + WB_W'(1);
          // Restart the count so VERIFY can reuse it for its CHAIN_LEN cycles.
          r_bit_cnt <= w_chain_last ? '0 : r_bit_cnt + CNT_W'(1);
        end
        S_VERIFY: begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (w_chain_last) begin
            r_error <= (w_ld_crc != crc8_step(w_rb_crc, cfg_sdi));
          end
        end
        default: ;
      endcase
    end
  end

  config_crc8 u_ld_crc (
    .clk (clk),
    .rst (rst),
    .clr (w_crc_clr),
    .en  (r_state == S_SHIFT),
    .din (r_word[WORD_W-1]),
    .crc (w_ld_crc)
  );

  config_crc8 u_rb_crc (
    .clk (clk),
    .rst (rst),
    .clr (w_crc_clr),
    .en  (r_state == S_VERIFY),
    .din (cfg_sdi),
    .crc (w_rb_crc)
  );

  assign s_ready   = r_s_ready;
  assign cfg_en    = r_cfg_en;
  assign cfg_shift = r_cfg_shift;
  // Recirculation must land in the same clock edge the bit leaves the chain,
  // so VERIFY passes cfg_sdi straight through; otherwise the word MSB flop.
  assign cfg_sdo   = (r_state == S_VERIFY) ? cfg_sdi : r_word[WORD_W-1];
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: scoreboard bench for config_loader.
// Two instances: 48-bit chain (main tests) and 20-bit chain (partial word).
// The driver pushes expected results per operation; a negedge monitor pops
// and checks chain contents, error, busy length and cfg_en whenever done fires.
module tb_config_loader;

  typedef struct {
    int          inst;
    logic [47:0] chain;
    logic        err;
    int          blen;
  } exp_t;

  localparam logic [47:0] BASIC = 48'hA53CFF00817E;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start = 1'b0, verify_en = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, cfg_en, cfg_shift, cfg_sdo, cfg_sdi, busy, done, error;

  logic       b_start = 1'b0, b_verify_en = 1'b0, b_s_valid = 1'b0;
  logic [7:0] b_s_data = '0;
  logic       b_s_ready, b_cfg_en, b_cfg_shift, b_cfg_sdo, b_cfg_sdi, b_busy, b_done, b_error;

  logic [47:0] chain   = '0;
  logic [19:0] chain20 = '0;
  int          shcnt   = 0;
  logic        fault_en = 1'b0;

  logic [7:0] words [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
  logic [7:0] pwords[4] = '{8'hF0, 8'h0F, 8'hC3, 8'hAA};

  exp_t q[$];
  exp_t e0, e1;
  int   n_cmp = 0, n_bad = 0;
  int   blen0 = 0, blen1 = 0, b_acc = 0;

  always #5 clk = ~clk;

  config_loader #(.CHAIN_LEN(48), .WORD_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .verify_en(verify_en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_en(cfg_en), .cfg_shift(cfg_shift), .cfg_sdo(cfg_sdo), .cfg_sdi(cfg_sdi),
    .busy(busy), .done(done), .error(error)
  );

  config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .clk(clk), .rst(rst), .start(b_start), .verify_en(b_verify_en),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .cfg_en(b_cfg_en), .cfg_shift(b_cfg_shift), .cfg_sdo(b_cfg_sdo), .cfg_sdi(b_cfg_sdi),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  // Chain models; optional single-bit fault injected as the load completes,
  // so the verify pass reads back a corrupted bit 10.
  assign cfg_sdi   = chain[47];
  assign b_cfg_sdi = chain20[19];

  always @(posedge clk) begin
    if (start && !busy) begin
      shcnt <= 0;
    end else if (cfg_en && cfg_shift) begin
      chain <= {chain[46:0], cfg_sdo} ^ ((fault_en && shcnt == 47) ? 48'h400 : 48'h0);
      shcnt <= shcnt + 1;
    end
    if (b_cfg_en && b_cfg_shift) chain20 <= {chain20[18:0], b_cfg_sdo};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      blen0 = 0;
      blen1 = 0;
    end else begin
      if (busy)   blen0++;
      if (b_busy) blen1++;
    end
    if (b_s_valid && b_s_ready) b_acc++;
    if (done) begin
      if (q.size() == 0) chk("done_without_expect", q.size(), 1);
      else begin
        e0 = q.pop_front();
        chk("done_inst48", 0, e0.inst);
        chk("chain48", chain, e0.chain);
        chk("error_at_done", error, e0.err);
        chk("busy_len48", blen0, e0.blen);
        chk("cfg_en_at_done", cfg_en, 0);
      end
      blen0 = 0;
    end
    if (b_done) begin
      if (q.size() == 0) chk("done20_without_expect", q.size(), 1);
      else begin
        e1 = q.pop_front();
        chk("done_inst20", 1, e1.inst);
        chk("chain20", {28'h0, chain20}, e1.chain);
        chk("error20_at_done", b_error, e1.err);
        chk("busy_len20", blen1, e1.blen);
        chk("cfg_en20_at_done", b_cfg_en, 0);
      end
      blen1 = 0;
    end
  end

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!s_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) timeout_fail(nm);
  endtask

  task automatic wait_b_ready(input string nm);
    int k = 0;
    while (!b_s_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!b_s_ready) timeout_fail(nm);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done) timeout_fail(nm);
  endtask

  task automatic run(input bit ver, input bit stall, input bit poke, input bit fault,
                     input logic [47:0] exp_chain, input bit exp_err, input int exp_blen);
    fault_en = fault;
    q.push_back('{0, exp_chain, exp_err, exp_blen});
    @(negedge clk);
    start = 1'b1;
    verify_en = ver;
    @(negedge clk);
    start = 1'b0;
    verify_en = 1'b0;
    chk("after_start_busy_en_ready_err", {busy, cfg_en, s_ready, error}, 4'b1110);
    for (int i = 0; i < 6; i++) begin
      if (stall && i > 0) begin
        wait_ready("stall_fetch");
        for (int s = 0; s < 5; s++) begin
          chk("stall_ready_noshift", {s_ready, cfg_shift}, 2'b10);
          @(negedge clk);
        end
      end
      s_data  = words[i];
      s_valid = 1'b1;
      wait_ready("word_handshake");
      @(negedge clk);
      s_valid = 1'b0;
      if (poke && i == 2) begin
        start = 1'b1;
        verify_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        verify_en = 1'b0;
      end
    end
    wait_done("wait_done");
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("error_after_done", error, exp_err);
      chk("cfg_en_after_done", cfg_en, 0);
    end
    fault_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs48", {s_ready, cfg_en, cfg_shift, cfg_sdo, busy, done, error}, 7'b0);
    chk("reset_outputs20", {b_s_ready, b_cfg_en, b_cfg_shift, b_cfg_sdo, b_busy, b_done, b_error}, 7'b0);

    run(0, 0, 0, 0, BASIC, 0, 54);             // basic load
    run(1, 0, 0, 0, BASIC, 0, 102);            // verify, healthy chain
    run(1, 0, 0, 1, BASIC ^ 48'h400, 1, 102);  // verify, bit 10 corrupted
    run(0, 1, 0, 0, BASIC, 0, 79);             // 5-cycle stalls before words 2..6
    run(0, 0, 1, 0, BASIC, 0, 54);             // start pulsed while busy

    // Reset during SHIFT of word 2.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_data  = words[i];
      s_valid = 1'b1;
      wait_ready("rst_test_handshake");
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", {busy, cfg_shift}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("outputs_after_rst", {s_ready, cfg_en, cfg_shift, cfg_sdo, busy, done, error}, 7'b0);
    rst = 1'b0;
    run(0, 0, 0, 0, BASIC, 0, 54);             // clean reload after reset

    // Partial last word on the 20-bit chain.
    q.push_back('{1, 48'(20'hF00FC), 0, 23});
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_s_data  = pwords[i];
      b_s_valid = 1'b1;
      if (i < 3) begin
        wait_b_ready("partial_handshake");
        @(negedge clk);
      end
    end
    begin
      int k = 0;
      while (!b_done && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!b_done) timeout_fail("wait_done20");
    end
    repeat (4) @(negedge clk);
    b_s_valid = 1'b0;
    chk("words_accepted20", b_acc, 3);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
